// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4:1 one-bit mux channel arbiter.
//   NUM_REQ  number of requesters sharing the channel
//   SEL_W    width of the mux select / requester index
//   state_t  arbiter FSM encoding (ST_IDLE, ST_GRANT)
//   onehot() index -> one-hot requester vector
package mux4_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the requester-facing signals of the shared mux channel.
//   req    requests, bit i = requester i
//   I      data bits, I[i] from requester i
//   grant  one-hot grant (0 when idle)
//   s      mux select = index of the granted requester
//   valid  1 while a grant is active
//   y      channel output, I[s] gated by valid
//
// Handshake: a requester holds req[i] high for as long as it wants the
// channel. A grant is seen one cycle after the request is sampled; grant[i]
// together with valid marks every cycle in which requester i owns y.
// There is no ready/back-pressure: dropping req[i] releases the channel at
// the next edge.
interface mux4_rr_arbiter_if;
  import mux4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] I;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   s;
  logic               valid;
  logic               y;

  // Requester side
  modport master (
    output req, I,
    input  grant, s, valid, y
  );

  // Arbiter side
  modport slave (
    input  req, I,
    output grant, s, valid, y
  );

endinterface

// File: rtl/mux4_rr_arbiter_pick.sv
// rr_pick4: combinational round-robin picker.
//   req    candidate request vector
//   ptr    highest-priority index; search order ptr, ptr+1, ... mod 4
//   found  1 when any bit of req is set
//   idx    first set index in search order (ptr when nothing found)
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the lowest priority back to ptr so that the highest-priority
  // hit is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter and sequencer for the shared 4:1
// one-bit mux channel. Grants one requester at a time, drives the mux
// select and presents the owner's data bit on y. A burst limit forces the
// owner out after MAX_BURST consecutive cycles when others are waiting.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        channel signals (slave modport): req, I in; grant, s, valid, y out
//   state_dbg  current FSM state
//   ptr_dbg    current round-robin pointer
//   cnt_dbg    current burst counter
module mux4_rr_arbiter
  import mux4_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  mux4_rr_arbiter_if.slave    bus,
  output state_t              state_dbg,
  output logic [SEL_W-1:0]    ptr_dbg,
  output logic [CNT_W-1:0]    cnt_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  state_t             state_q, state_n;
  logic [SEL_W-1:0]   ptr_q, ptr_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic [SEL_W-1:0]   s_q, s_n;
  logic               valid_q, valid_n;

  logic [NUM_REQ-1:0] others;
  logic               owner_req;
  logic               at_limit;
  logic [NUM_REQ-1:0] pick_req;
  logic [SEL_W-1:0]   pick_ptr;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;

  // Requests other than the current owner; also the candidate set on a
  // release, which both covers the forced-out case and is harmless when the
  // owner has dropped its request anyway.
  assign others    = bus.req & ~onehot(s_q);
  assign owner_req = bus.req[s_q];
  assign at_limit  = (cnt_q == CNT_MAX);

  // One picker serves both the idle selection and the handover.
  always_comb begin
    if (state_q == ST_GRANT) begin
      pick_req = others;
      pick_ptr = s_q + 2'd1;
    end else begin
      pick_req = bus.req;
      pick_ptr = ptr_q;
    end
  end

  rr_pick4 u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    grant_n = grant_q;
    s_n     = s_q;
    valid_n = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_n = ST_GRANT;
          grant_n = onehot(pick_idx);
          s_n     = pick_idx;
          valid_n = 1'b1;
          cnt_n   = '0;
        end
      end
      ST_GRANT: begin
        if (owner_req && !(at_limit && (|others))) begin
          // Keep the grant; the counter saturates so a lone requester can
          // hold the channel indefinitely.
          if (!at_limit) cnt_n = cnt_q + 1'b1;
        end else begin
          ptr_n = s_q + 2'd1;
          cnt_n = '0;
          if (pick_found) begin
            // Same-edge handover, no idle bubble.
            grant_n = onehot(pick_idx);
            s_n     = pick_idx;
            valid_n = 1'b1;
          end else begin
            // s keeps its last value while idle.
            state_n = ST_IDLE;
            grant_n = '0;
            valid_n = 1'b0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
        valid_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      grant_q <= grant_n;
      s_q     <= s_n;
      valid_q <= valid_n;
    end
  end

  assign bus.grant = grant_q;
  assign bus.s     = s_q;
  assign bus.valid = valid_q;
  assign bus.y     = bus.I[s_q] & valid_q;

  assign state_dbg = state_q;
  assign ptr_dbg   = ptr_q;
  assign cnt_dbg   = cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: default build (MAX_BURST=4) plus a
// MAX_BURST=1 build for the rotate-every-cycle corner.
module tb_mux4_rr_arbiter;
  import mux4_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic rst1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  mux4_rr_arbiter_if bus0 ();
  mux4_rr_arbiter_if bus1 ();

  state_t     st0, st1;
  logic [1:0] ptr0, ptr1;
  logic [2:0] cnt0;
  logic [0:0] cnt1;

  mux4_rr_arbiter #(.MAX_BURST(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus0),
    .state_dbg (st0),
    .ptr_dbg   (ptr0),
    .cnt_dbg   (cnt0)
  );

  mux4_rr_arbiter #(.MAX_BURST(1), .CNT_W(1)) dut1 (
    .clk       (clk),
    .rst       (rst1),
    .bus       (bus1),
    .state_dbg (st1),
    .ptr_dbg   (ptr1),
    .cnt_dbg   (cnt1)
  );

  // ---------------- scoreboard ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic [3:0] req, input logic [3:0] din);
    bus0.req = req;
    bus0.I   = din;
  endtask

  task automatic check0(input string tag, input logic [3:0] g, input logic [1:0] s,
                        input logic v, input logic y);
    check({tag, ".grant"}, 32'(bus0.grant), 32'(g));
    check({tag, ".s"},     32'(bus0.s),     32'(s));
    check({tag, ".valid"}, 32'(bus0.valid), 32'(v));
    check({tag, ".y"},     32'(bus0.y),     32'(y));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst  = 1'b1;
    rst1 = 1'b1;
    drive0(4'hF, 4'hF);
    bus1.req = 4'h0;
    bus1.I   = 4'h0;
    #1;

    // 1: reset dominates req
    step();
    step();
    check0("rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("rst.state", 32'(st0), 32'(ST_IDLE));
    check("rst.ptr", 32'(ptr0), 32'd0);
    rst = 1'b0;
    step();
    check0("first", 4'b0001, 2'd0, 1'b1, 1'b1);

    // 2: all request, burst of 4 each, order 0,1,2,3,0, no bubble
    for (int i = 0; i < 3; i++) exp_q.push_back(4'b0001);
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b0010);
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b0100);
    for (int i = 0; i < 4; i++) exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    while (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      step();
      check("burst.grant", 32'(bus0.grant), 32'(e));
      check("burst.valid", 32'(bus0.valid), 32'd1);
    end
    check("burst.ptr", 32'(ptr0), 32'd0);
    check("burst.cnt", 32'(cnt0), 32'd0);

    // 3: lone requester 2 keeps the grant, y follows I[2]
    drive0(4'b0100, 4'b0100);
    step();
    for (int i = 0; i < 10; i++) begin
      check0("lone", 4'b0100, 2'd2, 1'b1, 1'b1);
      step();
    end
    check("lone.cnt", 32'(cnt0), 32'd3);

    // 4: move to owner 3, then 3 drops while 0 rises -> wrap to 0
    drive0(4'b1000, 4'b0000);
    step();
    check0("own3", 4'b1000, 2'd3, 1'b1, 1'b0);
    drive0(4'b0001, 4'b0001);
    step();
    check0("wrap", 4'b0001, 2'd0, 1'b1, 1'b1);

    // 5: owner 1, drop all -> idle, ptr=2, then 0011 -> requester 0
    drive0(4'b0010, 4'b0000);
    step();
    check0("own1", 4'b0010, 2'd1, 1'b1, 1'b0);
    drive0(4'b0000, 4'b1111);
    step();
    check0("drop", 4'b0000, 2'd1, 1'b0, 1'b0);
    check("drop.state", 32'(st0), 32'(ST_IDLE));
    check("drop.ptr", 32'(ptr0), 32'd2);
    drive0(4'b0011, 4'b0001);
    step();
    check0("rereq", 4'b0001, 2'd0, 1'b1, 1'b1);

    // 6: reset in the middle of a burst
    step();
    step();
    check("mid.cnt", 32'(cnt0), 32'd2);
    rst = 1'b1;
    step();
    check0("midrst", 4'b0000, 2'd0, 1'b0, 1'b0);
    check("midrst.ptr", 32'(ptr0), 32'd0);
    check("midrst.cnt", 32'(cnt0), 32'd0);
    check("midrst.state", 32'(st0), 32'(ST_IDLE));
    rst = 1'b0;
    drive0(4'b0000, 4'b0000);
    step();
    check0("idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // MAX_BURST=1: rotate every cycle, lone requester keeps grant
    rst1     = 1'b0;
    bus1.req = 4'hF;
    bus1.I   = 4'b1010;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    while (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      step();
      check("mb1.grant", 32'(bus1.grant), 32'(e));
    end
    check("mb1.y", 32'(bus1.y), 32'd0);
    bus1.req = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mb1.lone", 32'(bus1.grant), 32'(4'b0100));
    end
    check("mb1.lone.y", 32'(bus1.y), 32'd0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
